// File: rtl/mc97_pcm_fifo.sv
// mc97_pcm_fifo: playback/capture sample FIFOs between host audio logic and mc97 (clk domain); MC97_PCM_FIFO_PREFILL_EN gates playback until PREFILL samples are buffered
module mc97_pcm_fifo #(
  parameter int DEPTH = 64,
  parameter int LW = $clog2(DEPTH) + 1,
  parameter int PREFILL = DEPTH / 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   pb_wdata,
  input  logic          pb_we,
  output logic          pb_full,
  output logic [LW-1:0] pb_level,
  output logic [15:0]   pcm_out_data,
  input  logic          pcm_out_ack,
  input  logic [15:0]   pcm_in_data,
  input  logic          pcm_in_stb,
  output logic [15:0]   cap_rdata,
  input  logic          cap_re,
  output logic          cap_empty,
  output logic [LW-1:0] cap_level,
  output logic          stat_pb_urun,
  output logic          stat_pb_orun,
  output logic          stat_cap_orun,
  input  logic          stat_clr
);
  localparam int AW = $clog2(DEPTH);
  logic [15:0] pb_mem [DEPTH];
  logic [15:0] cap_mem [DEPTH];
  logic [AW-1:0] pb_wp, pb_rp, cap_wp, cap_rp;
  logic play, pb_pop, pb_wr, pb_urun_ev, pb_orun_ev, cap_pop, cap_push, cap_orun_ev;
`ifdef MC97_PCM_FIFO_PREFILL_EN
  typedef enum logic {SILENT, PLAY} pb_state_t;
  pb_state_t state, state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SILENT;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    state_nx = state == SILENT ? (pb_level >= LW'(PREFILL) ? PLAY : SILENT)
                               : (pb_urun_ev ? SILENT : PLAY);
  end
  assign play = state == PLAY;
`else
  assign play = PREFILL >= 0;
`endif
  assign pb_full = pb_level == LW'(DEPTH);
  assign cap_empty = cap_level == '0;
  always_comb begin
    pb_pop = pcm_out_ack && play && pb_level != '0;
    pb_wr = pb_we && (!pb_full || pb_pop);
    pb_urun_ev = pcm_out_ack && play && pb_level == '0;
    pb_orun_ev = pb_we && !pb_wr;
    cap_pop = cap_re && !cap_empty;
    cap_push = pcm_in_stb && (cap_level != LW'(DEPTH) || cap_pop);
    cap_orun_ev = pcm_in_stb && !cap_push;
    pcm_out_data = (play && pb_level != '0) ? pb_mem[pb_rp] : 16'h0000;
    cap_rdata = cap_empty ? 16'h0000 : cap_mem[cap_rp];
  end
  always_ff @(posedge clk) begin
    if (pb_wr) pb_mem[pb_wp] <= pb_wdata;
    if (cap_push) cap_mem[cap_wp] <= pcm_in_data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_wp <= '0;
      pb_rp <= '0;
      pb_level <= '0;
      cap_wp <= '0;
      cap_rp <= '0;
      cap_level <= '0;
      stat_pb_urun <= 1'b0;
      stat_pb_orun <= 1'b0;
      stat_cap_orun <= 1'b0;
    end else begin
      pb_wp <= pb_wp + AW'(pb_wr);
      pb_rp <= pb_rp + AW'(pb_pop);
      pb_level <= pb_level + LW'(pb_wr) - LW'(pb_pop);
      cap_wp <= cap_wp + AW'(cap_push);
      cap_rp <= cap_rp + AW'(cap_pop);
      cap_level <= cap_level + LW'(cap_push) - LW'(cap_pop);
      stat_pb_urun <= pb_urun_ev || (stat_pb_urun && !stat_clr);
      stat_pb_orun <= pb_orun_ev || (stat_pb_orun && !stat_clr);
      stat_cap_orun <= cap_orun_ev || (stat_cap_orun && !stat_clr);
    end
  end
endmodule

// File: tb/tb_mc97_pcm_fifo.sv
// tb_mc97_pcm_fifo: directed self-checking bench for mc97_pcm_fifo
module tb_mc97_pcm_fifo;
  localparam int DEPTH = 64;
  localparam int LW = 7;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] pb_wdata = '0, pcm_in_data = '0;
  logic pb_we = 1'b0, pcm_out_ack = 1'b0, pcm_in_stb = 1'b0, cap_re = 1'b0, stat_clr = 1'b0;
  logic pb_full, cap_empty, stat_pb_urun, stat_pb_orun, stat_cap_orun;
  logic [LW-1:0] pb_level, cap_level;
  logic [15:0] pcm_out_data, cap_rdata;
  int tests = 0, fails = 0;
  mc97_pcm_fifo #(.DEPTH(DEPTH), .PREFILL(DEPTH / 2)) dut (
    .clk(clk), .rst(rst), .pb_wdata(pb_wdata), .pb_we(pb_we), .pb_full(pb_full),
    .pb_level(pb_level), .pcm_out_data(pcm_out_data), .pcm_out_ack(pcm_out_ack),
    .pcm_in_data(pcm_in_data), .pcm_in_stb(pcm_in_stb), .cap_rdata(cap_rdata),
    .cap_re(cap_re), .cap_empty(cap_empty), .cap_level(cap_level),
    .stat_pb_urun(stat_pb_urun), .stat_pb_orun(stat_pb_orun),
    .stat_cap_orun(stat_cap_orun), .stat_clr(stat_clr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask
  task automatic write_pb(input logic [15:0] d);
    pb_wdata = d;
    pb_we = 1'b1;
    step();
    pb_we = 1'b0;
  endtask
  task automatic ack_pb();
    pcm_out_ack = 1'b1;
    step();
    pcm_out_ack = 1'b0;
  endtask
  task automatic push_cap(input logic [15:0] d);
    pcm_in_data = d;
    pcm_in_stb = 1'b1;
    step();
    pcm_in_stb = 1'b0;
  endtask
  task automatic pop_cap();
    cap_re = 1'b1;
    step();
    cap_re = 1'b0;
  endtask
  task automatic clr_stat();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
  endtask
  task automatic test_reset();
    write_pb(16'h1111);
    push_cap(16'h2222);
    ack_pb();
    ack_pb();
    rst = 1'b1;
    step();
    tests++; if (pb_level !== 7'd0 || cap_level !== 7'd0) begin fails++; $display("FAIL reset_level pb=%0d cap=%0d want 0/0", pb_level, cap_level); end
    tests++; if (pb_full !== 1'b0 || cap_empty !== 1'b1) begin fails++; $display("FAIL reset_flags full=%b empty=%b want 0/1", pb_full, cap_empty); end
    tests++; if (pcm_out_data !== 16'h0 || cap_rdata !== 16'h0) begin fails++; $display("FAIL reset_data out=%h cap=%h want 0000/0000", pcm_out_data, cap_rdata); end
    tests++; if ({stat_pb_urun, stat_pb_orun, stat_cap_orun} !== 3'b000) begin fails++; $display("FAIL reset_stat got %b want 000", {stat_pb_urun, stat_pb_orun, stat_cap_orun}); end
    rst = 1'b0;
    step();
  endtask
  task automatic test_playback_basic();
    do_reset();
    write_pb(16'hcafe);
    write_pb(16'hbabe);
    tests++; if (pb_level !== 7'd2 || pcm_out_data !== 16'hcafe) begin fails++; $display("FAIL pb_two_writes level=%0d data=%h want 2/cafe", pb_level, pcm_out_data); end
    ack_pb();
    tests++; if (pb_level !== 7'd1 || pcm_out_data !== 16'hbabe) begin fails++; $display("FAIL pb_first_ack level=%0d data=%h want 1/babe", pb_level, pcm_out_data); end
    ack_pb();
    tests++; if (pb_level !== 7'd0 || pcm_out_data !== 16'h0 || stat_pb_urun !== 1'b0) begin fails++; $display("FAIL pb_second_ack level=%0d data=%h urun=%b want 0/0000/0", pb_level, pcm_out_data, stat_pb_urun); end
  endtask
  task automatic test_underrun();
    do_reset();
    ack_pb();
    tests++; if (pcm_out_data !== 16'h0 || stat_pb_urun !== 1'b1 || pb_level !== 7'd0) begin fails++; $display("FAIL urun_set data=%h urun=%b level=%0d want 0000/1/0", pcm_out_data, stat_pb_urun, pb_level); end
    clr_stat();
    tests++; if (stat_pb_urun !== 1'b0) begin fails++; $display("FAIL urun_clear got %b want 0", stat_pb_urun); end
    stat_clr = 1'b1;
    pcm_out_ack = 1'b1;
    step();
    stat_clr = 1'b0;
    pcm_out_ack = 1'b0;
    tests++; if (stat_pb_urun !== 1'b1) begin fails++; $display("FAIL urun_set_beats_clr got %b want 1", stat_pb_urun); end
  endtask
  task automatic test_overrun_order();
    do_reset();
    write_pb(16'hcafe);
    ack_pb();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) write_pb(16'(p * 256 + i));
      tests++; if (pb_full !== 1'b1 || pb_level !== 7'd64) begin fails++; $display("FAIL fill_full pass=%0d full=%b level=%0d want 1/64", p, pb_full, pb_level); end
      write_pb(16'hffff);
      tests++; if (stat_pb_orun !== 1'b1 || pb_level !== 7'd64) begin fails++; $display("FAIL orun_drop pass=%0d orun=%b level=%0d want 1/64", p, stat_pb_orun, pb_level); end
      clr_stat();
      for (int i = 0; i < DEPTH; i++) begin
        tests++; if (pcm_out_data !== 16'(p * 256 + i)) begin fails++; $display("FAIL drain_order pass=%0d idx=%0d got %h want %h", p, i, pcm_out_data, 16'(p * 256 + i)); end
        ack_pb();
      end
      tests++; if (pb_level !== 7'd0 || pb_full !== 1'b0 || pcm_out_data !== 16'h0 || stat_pb_urun !== 1'b0) begin fails++; $display("FAIL drained pass=%0d level=%0d full=%b data=%h urun=%b want 0/0/0000/0", p, pb_level, pb_full, pcm_out_data, stat_pb_urun); end
    end
  endtask
  task automatic test_full_we_ack();
    do_reset();
    for (int i = 0; i < DEPTH; i++) write_pb(16'(i));
    pb_wdata = 16'haaaa;
    pb_we = 1'b1;
    pcm_out_ack = 1'b1;
    step();
    pb_we = 1'b0;
    pcm_out_ack = 1'b0;
    tests++; if (pb_level !== 7'd64 || stat_pb_orun !== 1'b0 || pcm_out_data !== 16'd1) begin fails++; $display("FAIL full_we_ack level=%0d orun=%b data=%h want 64/0/0001", pb_level, stat_pb_orun, pcm_out_data); end
    for (int i = 1; i < DEPTH; i++) ack_pb();
    tests++; if (pcm_out_data !== 16'haaaa || pb_level !== 7'd1) begin fails++; $display("FAIL full_we_ack_last data=%h level=%0d want aaaa/1", pcm_out_data, pb_level); end
  endtask
  task automatic test_empty_we_ack();
    do_reset();
    pb_wdata = 16'h5555;
    pb_we = 1'b1;
    pcm_out_ack = 1'b1;
    step();
    pb_we = 1'b0;
    pcm_out_ack = 1'b0;
    tests++; if (pb_level !== 7'd1 || stat_pb_urun !== 1'b1 || pcm_out_data !== 16'h5555) begin fails++; $display("FAIL empty_we_ack level=%0d urun=%b data=%h want 1/1/5555", pb_level, stat_pb_urun, pcm_out_data); end
  endtask
  task automatic test_capture();
    do_reset();
    push_cap(16'h1234);
    push_cap(16'h5678);
    tests++; if (cap_level !== 7'd2 || cap_rdata !== 16'h1234 || cap_empty !== 1'b0) begin fails++; $display("FAIL cap_two level=%0d data=%h empty=%b want 2/1234/0", cap_level, cap_rdata, cap_empty); end
    pop_cap();
    tests++; if (cap_level !== 7'd1 || cap_rdata !== 16'h5678) begin fails++; $display("FAIL cap_pop level=%0d data=%h want 1/5678", cap_level, cap_rdata); end
    pop_cap();
    pop_cap();
    tests++; if (cap_level !== 7'd0 || cap_empty !== 1'b1 || cap_rdata !== 16'h0 || stat_cap_orun !== 1'b0) begin fails++; $display("FAIL cap_empty_pop level=%0d empty=%b data=%h orun=%b want 0/1/0000/0", cap_level, cap_empty, cap_rdata, stat_cap_orun); end
    for (int i = 0; i <= DEPTH; i++) push_cap(16'(i));
    tests++; if (stat_cap_orun !== 1'b1 || cap_level !== 7'd64 || cap_rdata !== 16'h0) begin fails++; $display("FAIL cap_orun orun=%b level=%0d data=%h want 1/64/0000", stat_cap_orun, cap_level, cap_rdata); end
    clr_stat();
    pcm_in_data = 16'hbeef;
    pcm_in_stb = 1'b1;
    cap_re = 1'b1;
    step();
    pcm_in_stb = 1'b0;
    cap_re = 1'b0;
    tests++; if (stat_cap_orun !== 1'b0 || cap_level !== 7'd64 || cap_rdata !== 16'd1) begin fails++; $display("FAIL cap_full_stb_re orun=%b level=%0d data=%h want 0/64/0001", stat_cap_orun, cap_level, cap_rdata); end
    for (int i = 1; i < DEPTH; i++) begin
      tests++; if (cap_rdata !== 16'(i)) begin fails++; $display("FAIL cap_order idx=%0d got %h want %h", i, cap_rdata, 16'(i)); end
      pop_cap();
    end
    tests++; if (cap_rdata !== 16'hbeef || cap_level !== 7'd1) begin fails++; $display("FAIL cap_last data=%h level=%0d want beef/1", cap_rdata, cap_level); end
  endtask
  task automatic test_prefill();
    do_reset();
    for (int i = 0; i < 31; i++) begin
      pb_wdata = 16'(16'h100 + i);
      pb_we = 1'b1;
      pcm_out_ack = 1'b1;
      step();
    end
    pb_we = 1'b0;
    pcm_out_ack = 1'b0;
    tests++; if (pb_level !== 7'd31 || pcm_out_data !== 16'h0 || stat_pb_urun !== 1'b0) begin fails++; $display("FAIL prefill_silent level=%0d data=%h urun=%b want 31/0000/0", pb_level, pcm_out_data, stat_pb_urun); end
    write_pb(16'h11f);
    step();
    tests++; if (pcm_out_data !== 16'h100 || pb_level !== 7'd32) begin fails++; $display("FAIL prefill_play data=%h level=%0d want 0100/32", pcm_out_data, pb_level); end
    for (int i = 0; i < 32; i++) begin
      tests++; if (pcm_out_data !== 16'(16'h100 + i)) begin fails++; $display("FAIL prefill_order idx=%0d got %h want %h", i, pcm_out_data, 16'(16'h100 + i)); end
      ack_pb();
    end
    tests++; if (pb_level !== 7'd0 || stat_pb_urun !== 1'b0) begin fails++; $display("FAIL prefill_drained level=%0d urun=%b want 0/0", pb_level, stat_pb_urun); end
    ack_pb();
    tests++; if (stat_pb_urun !== 1'b1) begin fails++; $display("FAIL prefill_urun got %b want 1", stat_pb_urun); end
    write_pb(16'h7777);
    tests++; if (pcm_out_data !== 16'h0 || pb_level !== 7'd1) begin fails++; $display("FAIL prefill_back_silent data=%h level=%0d want 0000/1", pcm_out_data, pb_level); end
  endtask
  initial begin
    test_reset();
`ifdef MC97_PCM_FIFO_PREFILL_EN
    test_prefill();
`else
    test_playback_basic();
    test_underrun();
    test_overrun_order();
    test_full_we_ack();
    test_empty_we_ack();
`endif
    test_capture();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
